// File: rtl/io_bus_parser_bank_pkg.sv
// rtl/io_bus_parser_bank_pkg.sv - shared widths and slot state type for the IO register bank
package io_bus_pkg;
  localparam int IO_DATA_W = 8;
  localparam int IO_ADDR_W = 16;

  typedef enum logic [0:0] {
    SLOT_IDLE = 1'b0,
    SLOT_HOLD = 1'b1
  } slot_state_t;
endpackage

// File: rtl/io_bus_parser_bank_if.sv
// rtl/io_bus_parser_bank_if.sv - CPU control lines and per-register peripheral ports of the bank
interface io_bus_parser_bank_if #(
  parameter int NUM_REGS = 4
);
  import io_bus_pkg::*;

  logic [IO_ADDR_W-1:0]          I_ADDR_BUS;
  logic                          I_WE_BUS_L;
  logic                          I_RE_BUS_L;
  logic [IO_DATA_W*NUM_REGS-1:0] I_DATA_WR;
  logic [NUM_REGS-1:0]           I_REG_WR_EN;
  logic [NUM_REGS-1:0]           O_WAIT;
  logic [IO_DATA_W*NUM_REGS-1:0] O_DATA_READ;
  logic [NUM_REGS-1:0]           O_BUS_WR_STB;
  logic [NUM_REGS-1:0]           O_BUS_RD_STB;

  modport master (
    output I_ADDR_BUS, I_WE_BUS_L, I_RE_BUS_L, I_DATA_WR, I_REG_WR_EN,
    input  O_WAIT, O_DATA_READ, O_BUS_WR_STB, O_BUS_RD_STB
  );

  modport slave (
    input  I_ADDR_BUS, I_WE_BUS_L, I_RE_BUS_L, I_DATA_WR, I_REG_WR_EN,
    output O_WAIT, O_DATA_READ, O_BUS_WR_STB, O_BUS_RD_STB
  );
endinterface

// File: rtl/io_bus_bank_slot.sv
// rtl/io_bus_bank_slot.sv - one bank register: bus/peripheral arbitration, hold buffer, strobes
// Bus write masking is compiled in with IO_BANK_WMASK_EN (mask supplied by the top).
module io_bus_bank_slot
  import io_bus_pkg::*;
#(
  parameter logic [IO_DATA_W-1:0] RESET_VAL = '0,
  parameter logic [IO_DATA_W-1:0] WMASK     = '1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bus_wr,
  input  logic                 i_bus_rd,
  input  logic [IO_DATA_W-1:0] i_bus_data,
  input  logic                 i_wr_en,
  input  logic [IO_DATA_W-1:0] i_wr_data,
  output logic                 o_wait,
  output logic [IO_DATA_W-1:0] o_data,
  output logic                 o_wr_stb,
  output logic                 o_rd_stb
);
  localparam logic [0:0] ST_IDLE = SLOT_IDLE;
  localparam logic [0:0] ST_HOLD = SLOT_HOLD;

  logic [0:0]           r_state;
  logic [IO_DATA_W-1:0] r_data;
  logic [IO_DATA_W-1:0] r_hold;
  logic                 r_wr_stb;
  logic                 r_rd_stb;
  logic [IO_DATA_W-1:0] w_bus_merged;

  assign w_bus_merged = (r_data & ~WMASK) | (i_bus_data & WMASK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_data   <= RESET_VAL;
      r_hold   <= '0;
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
    end else begin
      r_wr_stb <= i_bus_wr;
      r_rd_stb <= i_bus_rd;
      // The bus always wins the register; a colliding peripheral value is parked.
      if (i_bus_wr) begin
        r_data <= w_bus_merged;
        if (r_state == ST_IDLE && i_wr_en) begin
          r_hold  <= i_wr_data;
          r_state <= ST_HOLD;
        end
      end else if (r_state == ST_HOLD) begin
        r_data  <= r_hold;
        r_state <= ST_IDLE;
      end else if (i_wr_en) begin
        r_data <= i_wr_data;
      end
    end
  end

  assign o_wait   = (r_state == ST_HOLD) | ((r_state == ST_IDLE) & i_wr_en & i_bus_wr);
  assign o_data   = r_data;
  assign o_wr_stb = r_wr_stb;
  assign o_rd_stb = r_rd_stb;
endmodule

// File: rtl/io_bus_parser_bank.sv
// rtl/io_bus_parser_bank.sv - bank of memory-mapped IO registers with shared tri-state bus decode
// Optional build macro IO_BANK_WMASK_EN restricts CPU writes to the BUS_WMASK bits.
module io_bus_parser_bank
  import io_bus_pkg::*;
#(
  parameter logic [IO_ADDR_W-1:0]          BASE_ADDR  = 16'hFF40,
  parameter int                            NUM_REGS   = 4,
  parameter logic [IO_DATA_W*NUM_REGS-1:0] RESET_VALS = {NUM_REGS{8'h00}},
  parameter logic [IO_DATA_W*NUM_REGS-1:0] BUS_WMASK  = {NUM_REGS{8'hFF}}
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET_L,
  inout  wire  [IO_DATA_W-1:0] IO_DATA_BUS,
  io_bus_parser_bank_if.slave  bus_if
);
`ifdef IO_BANK_WMASK_EN
  localparam logic [IO_DATA_W*NUM_REGS-1:0] W_BUS_MASK = BUS_WMASK;
`else
  // Every bit is CPU-writable; the OR keeps the unused mask parameter referenced.
  localparam logic [IO_DATA_W*NUM_REGS-1:0] W_BUS_MASK = BUS_WMASK | {NUM_REGS{8'hFF}};
`endif

  logic [IO_ADDR_W:0]            w_diff;
  logic                          w_hit;
  logic [3:0]                    w_idx;
  logic                          w_bus_wr;
  logic                          w_rd_start;
  logic                          w_drive;
  logic [IO_DATA_W-1:0]          w_rd_data;
  logic [IO_DATA_W*NUM_REGS-1:0] w_data_read;
  logic [NUM_REGS-1:0]           w_wait;
  logic [NUM_REGS-1:0]           w_wr_stb;
  logic [NUM_REGS-1:0]           w_rd_stb;
  logic                          r_re_d;

  // 17-bit difference: a borrow means below the window, so a base near FFFF cannot wrap.
  assign w_diff     = {1'b0, bus_if.I_ADDR_BUS} - {1'b0, BASE_ADDR};
  assign w_hit      = !w_diff[IO_ADDR_W] && (w_diff[IO_ADDR_W-1:0] < IO_ADDR_W'(NUM_REGS));
  assign w_idx      = w_diff[3:0];
  assign w_bus_wr   = w_hit & ~bus_if.I_WE_BUS_L;
  assign w_rd_start = w_hit & r_re_d & ~bus_if.I_RE_BUS_L & bus_if.I_WE_BUS_L;
  assign w_drive    = w_hit & I_RESET_L & ~bus_if.I_RE_BUS_L & bus_if.I_WE_BUS_L;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) r_re_d <= 1'b1;
    else            r_re_d <= bus_if.I_RE_BUS_L;
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_idx == 4'(k)) w_rd_data = w_data_read[IO_DATA_W*k +: IO_DATA_W];
    end
  end

  assign IO_DATA_BUS = w_drive ? w_rd_data : 'z;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
    io_bus_bank_slot #(
      .RESET_VAL (RESET_VALS[IO_DATA_W*k +: IO_DATA_W]),
      .WMASK     (W_BUS_MASK[IO_DATA_W*k +: IO_DATA_W])
    ) u_slot (
      .i_clk      (I_CLK),
      .i_rst_n    (I_RESET_L),
      .i_bus_wr   (w_bus_wr & (w_idx == 4'(k))),
      .i_bus_rd   (w_rd_start & (w_idx == 4'(k))),
      .i_bus_data (IO_DATA_BUS),
      .i_wr_en    (bus_if.I_REG_WR_EN[k]),
      .i_wr_data  (bus_if.I_DATA_WR[IO_DATA_W*k +: IO_DATA_W]),
      .o_wait     (w_wait[k]),
      .o_data     (w_data_read[IO_DATA_W*k +: IO_DATA_W]),
      .o_wr_stb   (w_wr_stb[k]),
      .o_rd_stb   (w_rd_stb[k])
    );
  end

  assign bus_if.O_WAIT       = w_wait;
  assign bus_if.O_DATA_READ  = w_data_read;
  assign bus_if.O_BUS_WR_STB = w_wr_stb;
  assign bus_if.O_BUS_RD_STB = w_rd_stb;
endmodule
